ucie_ctl_rx_flow_buffer: RTL and testbench

- Parametrised RX buffer between the RDI receive side and the FDI delivery side of the UCIe controller.
- Adds FDI backpressure (ready), configurable depth, an almost-full watermark, a sticky/clearable overflow flag, and a link-state FSM with graceful drain on deactivation.
- Replaces the fixed-depth RX top buffering path.

---
 rtl/ucie_ctl_rx_pkg.sv | 19 +
 rtl/ucie_ctl_sync_fifo.sv | 71 +++++++
 rtl/ucie_ctl_rx_flow_buffer.sv | 115 +++++++++++
 tb/tb_ucie_ctl_rx_flow_buffer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ucie_ctl_rx_pkg.sv
// Shared types and constants for the UCIe controller RX flow buffer.
package ucie_ctl_rx_pkg;

    localparam int unsigned RX_NBYTES_DEF = 32;
    localparam int unsigned RX_DEPTH_DEF  = 16;

    // Link-state FSM encoding, also driven out directly on o_state.
    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_ACTIVE = 2'd1,
        RX_DRAIN  = 2'd2
    } rx_state_e;

    // Width of an occupancy counter that must be able to hold 0..depth inclusive.
    function automatic int unsigned rx_level_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/ucie_ctl_sync_fifo.sv
// First-word-fall-through synchronous FIFO: storage, wrapping pointers and an
// occupancy counter from which full/empty are derived.
module ucie_ctl_sync_fifo
    import ucie_ctl_rx_pkg::*;
#(
    parameter int unsigned DW    = 256,
    parameter int unsigned DEPTH = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               wr_en_i,
    input  logic [DW-1:0]                      wr_data_i,
    input  logic                               rd_en_i,
    output logic                               full_o,
    output logic                               empty_o,
    output logic [rx_level_width(DEPTH)-1:0]   level_o,
    output logic [DW-1:0]                      head_o
);

    localparam int unsigned LW = rx_level_width(DEPTH);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [LW-1:0] level_q;
    logic [LW-1:0] level_d;
    logic          wr_ok;
    logic          rd_ok;

    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;

    // Self-protecting handshakes: never read an empty FIFO, never overwrite a
    // full one unless the head leaves in the same cycle.
    assign rd_ok = rd_en_i && !empty_o;
    assign wr_ok = wr_en_i && (!full_o || rd_ok);

    // Head word is gated to zero while empty so reset/empty always shows 0.
    assign head_o = empty_o ? '0 : mem_q[rd_ptr_q];

    // Next occupancy: +1 write-only, -1 read-only, unchanged otherwise.
    always_comb begin
        level_d = level_q;
        case ({wr_ok, rd_ok})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Pointers wrap naturally modulo DEPTH (power of two); level tracks occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (wr_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (rd_ok) rd_ptr_q <= rd_ptr_q + PW'(1);
            level_q <= level_d;
        end
    end

    // Storage array; contents need no reset because level gates visibility.
    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/ucie_ctl_rx_flow_buffer.sv
// RX flow buffer between RDI receive and FDI delivery: link-state FSM with
// graceful drain, FDI backpressure, almost-full watermark and sticky overflow.
module ucie_ctl_rx_flow_buffer
    import ucie_ctl_rx_pkg::*;
#(
    parameter int unsigned NBYTES       = RX_NBYTES_DEF,
    parameter int unsigned DEPTH        = RX_DEPTH_DEF,
    parameter int unsigned AFULL_THRESH = DEPTH - 4
) (
    input  logic                               i_clk,
    input  logic                               i_rst,
    input  logic                               i_state_request,
    input  logic [NBYTES*8-1:0]                i_rdi_pl_data,
    input  logic                               i_rdi_pl_valid,
    input  logic                               i_fdi_ready,
    input  logic                               i_overflow_clear,
    output logic [NBYTES*8-1:0]                o_fdi_data,
    output logic                               o_fdi_data_valid,
    output logic                               o_overflow_detected,
    output logic                               o_almost_full,
    output logic [rx_level_width(DEPTH)-1:0]   o_level,
    output logic [1:0]                         o_state
);

    localparam int unsigned DW = NBYTES * 8;
    localparam int unsigned LW = rx_level_width(DEPTH);

    rx_state_e     state_q;
    rx_state_e     state_d;
    logic          ovf_q;
    logic          ovf_d;
    logic          afull_q;
    logic          afull_d;
    logic          fifo_full;
    logic          fifo_empty;
    logic [LW-1:0] fifo_level;
    logic [LW-1:0] level_next;
    logic          wr_en;
    logic          rd_en;
    logic          ovf_event;
    logic          active;

    assign active    = (state_q == RX_ACTIVE);
    assign rd_en     = !fifo_empty && i_fdi_ready;
    assign wr_en     = i_rdi_pl_valid && active && (!fifo_full || rd_en);
    // Only a rejected write while ACTIVE counts as overflow; IDLE/DRAIN drops are silent.
    assign ovf_event = i_rdi_pl_valid && active && fifo_full && !rd_en;

    ucie_ctl_sync_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (i_clk),
        .rst       (i_rst),
        .wr_en_i   (wr_en),
        .wr_data_i (i_rdi_pl_data),
        .rd_en_i   (rd_en),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .level_o   (fifo_level),
        .head_o    (o_fdi_data)
    );

    // Occupancy after this edge, used by the watermark and the drain-done check.
    always_comb begin
        level_next = fifo_level;
        case ({wr_en, rd_en})
            2'b10:   level_next = fifo_level + LW'(1);
            2'b01:   level_next = fifo_level - LW'(1);
            default: level_next = fifo_level;
        endcase
    end

    // Link-state next state; a re-request in DRAIN wins over the empty check.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RX_IDLE:   if (i_state_request) state_d = RX_ACTIVE;
            RX_ACTIVE: if (!i_state_request) state_d = RX_DRAIN;
            RX_DRAIN: begin
                if (i_state_request)       state_d = RX_ACTIVE;
                else if (level_next == '0) state_d = RX_IDLE;
            end
            default:   state_d = RX_IDLE;
        endcase
    end

    // Sticky overflow (set beats clear) and registered watermark from next level.
    always_comb begin
        ovf_d   = ovf_q;
        afull_d = (level_next >= LW'(AFULL_THRESH));
        if (ovf_event)             ovf_d = 1'b1;
        else if (i_overflow_clear) ovf_d = 1'b0;
    end

    // Control state registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= RX_IDLE;
            ovf_q   <= 1'b0;
            afull_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ovf_q   <= ovf_d;
            afull_q <= afull_d;
        end
    end

    assign o_fdi_data_valid    = !fifo_empty;
    assign o_overflow_detected = ovf_q;
    assign o_almost_full       = afull_q;
    assign o_level             = fifo_level;
    assign o_state             = state_q;

endmodule

// File: tb/tb_ucie_ctl_rx_flow_buffer.sv
// Directed + randomized bench for ucie_ctl_rx_flow_buffer against a queue model.
module tb_ucie_ctl_rx_flow_buffer;

    localparam int NB    = 32;
    localparam int DW    = NB * 8;
    localparam int DEPTH = 16;
    localparam int AF    = DEPTH - 4;
    localparam int LW    = $clog2(DEPTH + 1);

    logic          clk;
    logic          i_rst;
    logic          i_state_request;
    logic [DW-1:0] i_rdi_pl_data;
    logic          i_rdi_pl_valid;
    logic          i_fdi_ready;
    logic          i_overflow_clear;
    logic [DW-1:0] o_fdi_data;
    logic          o_fdi_data_valid;
    logic          o_overflow_detected;
    logic          o_almost_full;
    logic [LW-1:0] o_level;
    logic [1:0]    o_state;

    ucie_ctl_rx_flow_buffer #(
        .NBYTES       (NB),
        .DEPTH        (DEPTH),
        .AFULL_THRESH (AF)
    ) dut (
        .i_clk               (clk),
        .i_rst               (i_rst),
        .i_state_request     (i_state_request),
        .i_rdi_pl_data       (i_rdi_pl_data),
        .i_rdi_pl_valid      (i_rdi_pl_valid),
        .i_fdi_ready         (i_fdi_ready),
        .i_overflow_clear    (i_overflow_clear),
        .o_fdi_data          (o_fdi_data),
        .o_fdi_data_valid    (o_fdi_data_valid),
        .o_overflow_detected (o_overflow_detected),
        .o_almost_full       (o_almost_full),
        .o_level             (o_level),
        .o_state             (o_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a queue of buffered words plus link state (0 idle, 1 active, 2 drain).
    logic [DW-1:0] mq [$];
    int            mstate = 0;
    bit            movf   = 0;
    bit            maf    = 0;
    int            errors = 0;
    int            checks = 0;
    logic [DW-1:0] words [DEPTH+1];
    logic [DW-1:0] new_word;

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        for (int k = 0; k < NB / 4; k++) w[k*32 +: 32] = $urandom;
        return w;
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mstate = 0;
        movf   = 0;
        maf    = 0;
    endtask

    // Apply one clock edge worth of rules to the model using the current inputs.
    task automatic model_edge();
        int n;
        bit rd;
        bit wr;
        bit ov;
        bit act;
        if (i_rst) begin
            model_reset();
            return;
        end
        n   = mq.size();
        act = (mstate == 1);
        rd  = (n > 0) && i_fdi_ready;
        wr  = i_rdi_pl_valid && act && ((n < DEPTH) || rd);
        ov  = i_rdi_pl_valid && act && (n == DEPTH) && !rd;
        if (rd) void'(mq.pop_front());
        if (wr) mq.push_back(i_rdi_pl_data);
        if (ov) movf = 1;
        else if (i_overflow_clear) movf = 0;
        maf = (mq.size() >= AF);
        case (mstate)
            0: if (i_state_request) mstate = 1;
            1: if (!i_state_request) mstate = 2;
            default: begin
                if (i_state_request) mstate = 1;
                else if (mq.size() == 0) mstate = 0;
            end
        endcase
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".level"}, o_level, mq.size());
        chk({tag, ".valid"}, o_fdi_data_valid, mq.size() > 0);
        chk({tag, ".afull"}, o_almost_full, maf);
        chk({tag, ".ovf"}, o_overflow_detected, movf);
        chk({tag, ".state"}, o_state, mstate);
        if (mq.size() > 0) chk({tag, ".data"}, o_fdi_data, mq[0]);
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst = 1; i_state_request = 0; i_rdi_pl_data = '0; i_rdi_pl_valid = 0;
        i_fdi_ready = 0; i_overflow_clear = 0;
        step("rst");
        step("rst");
        chk("rst.data", o_fdi_data, '0);
        chk("rst.state", o_state, 0);

        // Activate, then two words with ready high.
        i_rst = 0; i_state_request = 1;
        step("act");
        chk("act.state", o_state, 1);
        i_rdi_pl_valid = 1; i_rdi_pl_data = DW'(8'hA5); i_fdi_ready = 1;
        step("wA5");
        chk("wA5.head", o_fdi_data, DW'(8'hA5));
        i_rdi_pl_data = DW'(8'h5A);
        step("w5A");
        chk("w5A.head", o_fdi_data, DW'(8'h5A));
        i_rdi_pl_valid = 0;
        step("idle1");
        chk("idle1.valid", o_fdi_data_valid, 0);
        chk("idle1.ovf", o_overflow_detected, 0);

        // Fill past full with ready low: 17th write overflows.
        i_fdi_ready = 0;
        for (int i = 0; i < 17; i++) begin
            i_rdi_pl_valid = 1; i_rdi_pl_data = rand_word(); words[i] = i_rdi_pl_data;
            step("fill");
            if (i == 10) chk("fill.af11", o_almost_full, 0);
            if (i == 11) chk("fill.af12", o_almost_full, 1);
            if (i == 15) chk("fill.ovf16", o_overflow_detected, 0);
            if (i == 16) chk("fill.ovf17", o_overflow_detected, 1);
        end
        chk("fill.level", o_level, DEPTH);
        i_rdi_pl_valid = 0; i_fdi_ready = 1;
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain.order", o_fdi_data, words[i]);
            step("drain");
        end
        chk("drain.empty", o_fdi_data_valid, 0);

        // Clear alone, then clear coinciding with an overflow write.
        i_overflow_clear = 1;
        step("clr");
        chk("clr.ovf", o_overflow_detected, 0);
        i_overflow_clear = 0; i_fdi_ready = 0;
        for (int i = 0; i < DEPTH; i++) begin
            i_rdi_pl_valid = 1; i_rdi_pl_data = rand_word(); words[i] = i_rdi_pl_data;
            step("refill");
        end
        i_overflow_clear = 1; i_rdi_pl_data = rand_word();
        step("setclr");
        chk("setclr.ovf", o_overflow_detected, 1);
        i_rdi_pl_valid = 0;
        step("clr2");
        chk("clr2.ovf", o_overflow_detected, 0);
        i_overflow_clear = 0;

        // Full with simultaneous read and write.
        i_rdi_pl_valid = 1; i_fdi_ready = 1; new_word = rand_word(); i_rdi_pl_data = new_word;
        step("rw");
        chk("rw.level", o_level, DEPTH);
        chk("rw.ovf", o_overflow_detected, 0);
        i_rdi_pl_valid = 0;
        for (int i = 1; i < DEPTH; i++) step("rwdrain");
        chk("rw.last", o_fdi_data, new_word);
        step("rwlast");

        // Drain on deactivation with five words held.
        i_fdi_ready = 0;
        for (int i = 0; i < 5; i++) begin
            i_rdi_pl_valid = 1; i_rdi_pl_data = rand_word();
            step("pre");
        end
        i_rdi_pl_valid = 0; i_state_request = 0;
        step("todrain");
        chk("todrain.state", o_state, 2);
        i_rdi_pl_valid = 1;
        for (int i = 0; i < 3; i++) begin
            i_rdi_pl_data = rand_word();
            step("drainwr");
        end
        chk("drainwr.level", o_level, 5);
        chk("drainwr.ovf", o_overflow_detected, 0);
        i_rdi_pl_valid = 0; i_fdi_ready = 1;
        for (int i = 0; i < 5; i++) step("drout");
        chk("drout.state", o_state, 0);
        chk("drout.valid", o_fdi_data_valid, 0);

        // Asynchronous reset mid-burst with eight words held.
        i_state_request = 1; i_fdi_ready = 0;
        step("react");
        for (int i = 0; i < 8; i++) begin
            i_rdi_pl_valid = 1; i_rdi_pl_data = rand_word();
            step("burst");
        end
        #2 i_rst = 1;
        #1;
        model_reset();
        chk("arst.valid", o_fdi_data_valid, 0);
        chk("arst.level", o_level, 0);
        chk("arst.data", o_fdi_data, '0);
        chk("arst.state", o_state, 0);
        chk("arst.afull", o_almost_full, 0);
        chk("arst.ovf", o_overflow_detected, 0);
        #1 i_rst = 0; i_state_request = 0; i_rdi_pl_valid = 0;
        step("postrst");
        i_state_request = 1;
        step("postact");
        chk("postact.state", o_state, 1);
        chk("postact.level", o_level, 0);

        // Randomized phase: slowly toggling request, random traffic.
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 14) == 0) i_state_request = !i_state_request;
            i_rdi_pl_valid   = ($urandom_range(0, 9) < 7);
            i_fdi_ready      = ($urandom_range(0, 1) == 1);
            i_overflow_clear = ($urandom_range(0, 9) == 0);
            i_rdi_pl_data    = rand_word();
            step("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
